// File: rtl/sar_adc_ctrl_if.sv
// sar_adc_ctrl_if: host <-> SAR controller bundle; the cont signal exists only when SAR_CONT_EN is defined
interface sar_adc_ctrl_if #(parameter int WIDTH = 8);
   logic ena;
   logic start;
   logic cmp_in;
`ifdef SAR_CONT_EN
   logic cont;
`endif
   logic [WIDTH-1:0] dac_code;
   logic [WIDTH-1:0] result;
   logic valid;
   logic busy;
`ifdef SAR_CONT_EN
   modport master (output ena, start, cmp_in, cont, input dac_code, result, valid, busy);
   modport slave (input ena, start, cmp_in, cont, output dac_code, result, valid, busy);
`else
   modport master (output ena, start, cmp_in, input dac_code, result, valid, busy);
   modport slave (input ena, start, cmp_in, output dac_code, result, valid, busy);
`endif
endinterface

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation controller driving an external R-2R DAC against an open-loop opamp comparator; SAR_CONT_EN adds free-running conversions
module sar_adc_ctrl #(
   parameter int WIDTH = 8,
   parameter int SETTLE_CYCLES = 4
) (
   input logic clk,
   input logic rst_n,
   sar_adc_ctrl_if.slave bus
);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] dac, dac_n, res, res_n;
   logic [IW-1:0] idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0] sync;
   logic cmp_s;
   logic cont_go;
`ifdef SAR_CONT_EN
   assign cont_go = bus.cont;
`else
   assign cont_go = 1'b0;
`endif
   assign cmp_s = sync[1];
   // comparator resynchronisation plus all controller state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
         state <= IDLE;
         dac <= '0;
         res <= '0;
         idx <= TOP;
         cnt <= '0;
      end else begin
         sync <= {sync[0], bus.cmp_in};
         state <= state_n;
         dac <= dac_n;
         res <= res_n;
         idx <= idx_n;
         cnt <= cnt_n;
      end
   end
   // next-state: ena low aborts from anywhere; SAMPLE resolves one bit and seeds the next trial
   always_comb begin
      state_n = state;
      dac_n = dac;
      res_n = res;
      idx_n = idx;
      cnt_n = cnt;
      if (!bus.ena) begin
         state_n = IDLE;
         dac_n = '0;
         idx_n = TOP;
         cnt_n = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_n = bus.start ? SETTLE : IDLE;
               dac_n = bus.start ? MSB : '0;
               idx_n = TOP;
               cnt_n = '0;
            end
            SETTLE: begin
               cnt_n = cnt + 1'b1;
               state_n = (cnt == CW'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
               dac_n[idx] = cmp_s;
               if (idx != '0) begin
                  dac_n[idx - 1'b1] = 1'b1;
                  idx_n = idx - 1'b1;
                  cnt_n = '0;
                  state_n = SETTLE;
               end else begin
                  res_n = dac_n;
                  state_n = DONE;
               end
            end
            DONE: begin
               state_n = cont_go ? SETTLE : IDLE;
               dac_n = cont_go ? MSB : '0;
               idx_n = TOP;
               cnt_n = '0;
            end
         endcase
      end
   end
   assign bus.dac_code = dac;
   assign bus.result = res;
   assign bus.valid = (state == DONE);
   assign bus.busy = (state == SETTLE) || (state == SAMPLE);
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: randomized self-checking bench with an ideal comparator and a bit-search reference model
module tb_sar_adc_ctrl;
   localparam int W = 8;
   localparam int S = 4;
   localparam int LAT = 1 + W * (S + 1);
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [W-1:0] vin = '0;
   int checks = 0;
   int failures = 0;
   sar_adc_ctrl_if #(.WIDTH(W)) bus ();
   sar_adc_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   assign bus.cmp_in = (vin >= bus.dac_code);
   // trial code presented for bit step i of a binary search towards v
   function automatic logic [W-1:0] trial_at(input logic [W-1:0] v, input int i);
      logic [W-1:0] code = '0;
      logic [W-1:0] t;
      for (int b = W - 1; b >= 0; b--) begin
         t = code | (W'(1) << b);
         if (b == W - 1 - i) return t;
         if (v >= t) code = t;
      end
      return '0;
   endfunction
   // run one start-triggered conversion and record what was observed each cycle
   task automatic convert(input logic [W-1:0] v, input int restart_at, input int ncyc,
                          output int vcyc, output int vcnt, output logic [W-1:0] res,
                          output int busy_bad, output int trial_bad);
      vin = v;
      vcyc = -1;
      vcnt = 0;
      res = 'x;
      busy_bad = 0;
      trial_bad = 0;
      @(negedge clk);
      bus.start = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         bus.start = (k == restart_at);
         if (bus.valid) begin
            vcnt++;
            vcyc = k;
            res = bus.result;
         end
         if (bus.busy !== (k < LAT)) busy_bad++;
         if (k < LAT && (k - 1) % (S + 1) == 0 && bus.dac_code !== trial_at(v, (k - 1) / (S + 1))) trial_bad++;
         if (k > LAT && bus.dac_code !== '0) trial_bad++;
      end
   endtask
   task automatic test_reset();
      bus.ena = 1'b0;
      bus.start = 1'b0;
`ifdef SAR_CONT_EN
      bus.cont = 1'b0;
`endif
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.dac_code, bus.result, bus.valid, bus.busy} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got dac=%h res=%h valid=%b busy=%b exp all zero", bus.dac_code, bus.result, bus.valid, bus.busy);
      end
      rst_n = 1'b1;
      bus.ena = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.dac_code !== '0) begin
         failures++;
         $display("FAIL idle_after_reset got busy=%b dac=%h exp 0/00", bus.busy, bus.dac_code);
      end
   endtask
   task automatic test_basic();
      int vcyc, vcnt, bb, tb;
      logic [W-1:0] r;
      convert(8'hA5, 0, 50, vcyc, vcnt, r, bb, tb);
      checks++;
      if (vcyc !== LAT || vcnt !== 1) begin
         failures++;
         $display("FAIL basic_valid got cycle=%0d count=%0d exp cycle=%0d count=1", vcyc, vcnt, LAT);
      end
      checks++;
      if (r !== 8'hA5) begin
         failures++;
         $display("FAIL basic_result got=%h exp=a5", r);
      end
      checks++;
      if (bb !== 0) begin
         failures++;
         $display("FAIL basic_busy got %0d bad cycles exp 0", bb);
      end
      checks++;
      if (tb !== 0) begin
         failures++;
         $display("FAIL basic_trials got %0d bad dac samples exp 0", tb);
      end
      checks++;
      if (bus.result !== 8'hA5) begin
         failures++;
         $display("FAIL basic_result_hold got=%h exp=a5", bus.result);
      end
   endtask
   task automatic test_extremes();
      int vcyc, vcnt, bb, tb;
      logic [W-1:0] r;
      logic [W-1:0] vals [2] = '{8'h00, 8'hFF};
      foreach (vals[i]) begin
         convert(vals[i], 0, 50, vcyc, vcnt, r, bb, tb);
         checks++;
         if (r !== vals[i] || vcnt !== 1 || vcyc !== LAT || bb !== 0 || tb !== 0) begin
            failures++;
            $display("FAIL extreme_%h got res=%h count=%0d cycle=%0d busy_bad=%0d trial_bad=%0d exp res=%h count=1 cycle=%0d", vals[i], r, vcnt, vcyc, bb, tb, vals[i], LAT);
         end
      end
   endtask
   task automatic test_random();
      int vcyc, vcnt, bb, tb;
      logic [W-1:0] r, v;
      for (int i = 0; i < 6; i++) begin
         v = W'($urandom_range(0, 255));
         convert(v, 0, 45, vcyc, vcnt, r, bb, tb);
         checks++;
         if (r !== v || vcnt !== 1 || vcyc !== LAT || bb !== 0 || tb !== 0) begin
            failures++;
            $display("FAIL random_%h got res=%h count=%0d cycle=%0d busy_bad=%0d trial_bad=%0d exp res=%h count=1 cycle=%0d", v, r, vcnt, vcyc, bb, tb, v, LAT);
         end
      end
   endtask
   task automatic test_restart_ignored();
      int vcyc, vcnt, bb, tb;
      logic [W-1:0] r;
      convert(8'h3C, 10, 50, vcyc, vcnt, r, bb, tb);
      checks++;
      if (r !== 8'h3C || vcnt !== 1 || vcyc !== LAT || bb !== 0 || tb !== 0) begin
         failures++;
         $display("FAIL restart_ignored got res=%h count=%0d cycle=%0d busy_bad=%0d trial_bad=%0d exp res=3c count=1 cycle=%0d", r, vcnt, vcyc, bb, tb, LAT);
      end
   endtask
   task automatic test_ena_abort();
      logic [W-1:0] prev;
      int vcnt = 0;
      int bad = 0;
      prev = bus.result;
      vin = W'($urandom_range(0, 255)) ^ 8'h81;
      @(negedge clk);
      bus.start = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         bus.start = (k == 30);
         if (bus.valid) vcnt++;
         if (bus.result !== prev) bad++;
         if (k > 20 && (bus.busy !== 1'b0 || bus.dac_code !== '0)) bad++;
         if (k == 20) bus.ena = 1'b0;
      end
      checks++;
      if (vcnt !== 0) begin
         failures++;
         $display("FAIL ena_abort_valid got %0d pulses exp 0", vcnt);
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL ena_abort_state got %0d bad cycles exp 0", bad);
      end
      bus.ena = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_async_reset();
      int vcyc, vcnt, bb, tb;
      int bad = 0;
      logic [W-1:0] r;
      vin = 8'hC7;
      @(negedge clk);
      bus.start = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.dac_code, bus.result, bus.valid, bus.busy} !== '0) begin
         failures++;
         $display("FAIL async_reset got dac=%h res=%h valid=%b busy=%b exp all zero", bus.dac_code, bus.result, bus.valid, bus.busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         if (bus.valid !== 1'b0 || bus.busy !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL async_reset_quiet got %0d active cycles exp 0", bad);
      end
      convert(8'h5A, 0, 45, vcyc, vcnt, r, bb, tb);
      checks++;
      if (r !== 8'h5A || vcnt !== 1 || vcyc !== LAT) begin
         failures++;
         $display("FAIL after_reset_conv got res=%h count=%0d cycle=%0d exp res=5a count=1 cycle=%0d", r, vcnt, vcyc, LAT);
      end
   endtask
`ifdef SAR_CONT_EN
   task automatic test_cont();
      int got [$];
      int exp [$] = '{LAT, 2 * LAT, 3 * LAT, 4 * LAT};
      int bad = 0;
      vin = 8'h77;
      bus.cont = 1'b1;
      @(negedge clk);
      bus.start = 1'b1;
      for (int k = 1; k <= 5 * LAT; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.valid) begin
            got.push_back(k);
            if (bus.result !== 8'h77) bad++;
         end
         if (k % LAT != 0 && k < 4 * LAT && bus.busy !== 1'b1) bad++;
         if (k == 3 * LAT + 1) bus.cont = 1'b0;
      end
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL cont_valid_cycles got %0d pulses first=%0d exp 4 pulses every %0d", got.size(), (got.size() > 0) ? got[0] : -1, LAT);
      end
      checks++;
      if (bad !== 0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL cont_state got %0d bad cycles busy=%b exp 0 bad, busy 0", bad, bus.busy);
      end
   endtask
`endif
   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_random();
      test_restart_ignored();
      test_ena_abort();
      test_async_reset();
`ifdef SAR_CONT_EN
      test_cont();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
